// File: rtl/seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_multiplier                                                  |
// | Purpose  : Sequential shift-add multiplier, one multiplier bit per clock.  |
// |            Start/done handshake, runtime signed/unsigned operand mode.     |
// | Ports    : clk, rst          - clock, synchronous active-high reset        |
// |            start             - request a multiply (honoured in IDLE/DONE)  |
// |            a, b, signed_mode - operands and mode, sampled on accept edge   |
// |            busy              - high while the multiply is running          |
// |            done              - one-cycle pulse, p holds a new result       |
// |            p                 - 2*WIDTH-bit product, held until next result |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int                PW       = 2 * WIDTH;
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   mag_a_q,  mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,  mag_b_d;
  logic               neg_q,    neg_d;
  logic [PW-1:0]      acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [PW-1:0]      p_q,      p_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic               w_accept;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [PW-1:0]      w_addend;
  logic [PW-1:0]      w_acc_sum;

  // Magnitudes fit in WIDTH unsigned bits: |-2^(W-1)| = 2^(W-1) is
  // representable, so the most-negative operand needs no extra bit.
  always_comb begin
    w_mag_a = a;
    w_mag_b = b;
    if (signed_mode && a[WIDTH-1]) begin
      w_mag_a = (~a) + WIDTH'(1);
    end
    if (signed_mode && b[WIDTH-1]) begin
      w_mag_b = (~b) + WIDTH'(1);
    end
  end

  // Partial product for this step: mag_a aligned to the bit being consumed.
  // The accumulator spans 2*WIDTH bits, so the sum can never overflow.
  always_comb begin
    w_addend  = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;
    w_acc_sum = acc_q + (mag_b_q[0] ? w_addend : '0);
  end

  assign w_accept = start && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (w_accept) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          mag_a_d = w_mag_a;
          mag_b_d = w_mag_b;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        // start and operand inputs are deliberately ignored here.
        acc_d   = w_acc_sum;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          // Negating zero gives zero, so a signed zero result stays 0.
          p_d     = neg_q ? ((~w_acc_sum) + PW'(1)) : w_acc_sum;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_multiplier                                               |
// | Purpose  : Directed self-checking bench for seq_multiplier, WIDTH=4 and 8. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        sm;
  logic        busy;
  logic        done;
  logic [7:0]  p;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        sm8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(sm),
    .busy(busy), .done(done), .p(p)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
    .busy(busy8), .done(done8), .p(p8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=4 multiply; lat = cycles from accept edge to done (20 = timeout).
  task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic ism, output int lat);
    a = ia; b = ib; sm = ism; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ism, output int lat);
    a8 = ia; b8 = ib; sm8 = ism; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int sx, sy, prod;
    logic [7:0] exp8;
    bit stop;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sm = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    tick(); tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_p",    64'(p),    64'd0);
    check("reset_p8",   64'(p8),   64'd0);
    rst = 1'b0;
    tick();

    // 15*15 unsigned with busy/done timing
    a = 4'd15; b = 4'd15; sm = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("run_busy", 64'(busy), 64'd1);
      check("run_done", 64'(done), 64'd0);
      if (i < 3) tick();
    end
    tick();
    check("u15x15_done", 64'(done), 64'd1);
    check("u15x15_busy", 64'(busy), 64'd0);
    check("u15x15_p",    64'(p),    64'hE1);
    tick();
    check("u15x15_done_pulse", 64'(done), 64'd0);
    check("u15x15_hold",       64'(p),    64'hE1);

    // signed corner cases
    run4(4'h8, 4'h8, 1'b1, lat);
    check("s_m8xm8_lat", 64'(lat), 64'd4);
    check("s_m8xm8_p",   64'(p),   64'h40);
    run4(4'h8, 4'h7, 1'b1, lat);
    check("s_m8x7_p",    64'(p),   64'hC8);
    run4(4'hD, 4'h0, 1'b1, lat);
    check("s_m3x0_p",    64'(p),   64'h00);
    tick();

    // back-to-back with start held; inputs toggled during RUN
    a = 4'd3; b = 4'd5; sm = 1'b0; start = 1'b1;
    tick();                                   // accept 3*5
    a = 4'd15; b = 4'd15; sm = 1'b1;
    tick(); tick(); tick();
    check("b2b_busy_mid", 64'(busy), 64'd1);
    a = 4'd4; b = 4'd4; sm = 1'b0;
    tick();
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_p1",    64'(p),    64'd15);
    tick();                                   // accept 4*4
    check("b2b_busy2", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    check("b2b_p1_held", 64'(p), 64'd15);
    a = 4'd11; b = 4'd13; sm = 1'b1;
    tick(); tick();
    start = 1'b0;
    tick();
    check("b2b_no_early_done", 64'(done), 64'd0);
    tick();
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_p2",    64'(p),    64'd16);
    tick();
    check("b2b_idle_busy", 64'(busy), 64'd0);
    check("b2b_idle_done", 64'(done), 64'd0);

    // reset in the middle of RUN
    a = 4'd9; b = 4'd9; sm = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_p",    64'(p),    64'd0);
    tick();
    check("rst_mid_idle", 64'(busy), 64'd0);
    run4(4'd2, 4'd3, 1'b0, lat);
    check("after_rst_lat", 64'(lat), 64'd4);
    check("after_rst_p",   64'(p),   64'd6);

    // exhaustive WIDTH=4 sweep, both modes, stop on first mismatch
    stop = 1'b0;
    for (int m = 0; m < 2 && !stop; m++) begin
      for (int x = 0; x < 16 && !stop; x++) begin
        for (int y = 0; y < 16 && !stop; y++) begin
          run4(4'(x), 4'(y), m[0], lat);
          sx   = (m == 1 && x >= 8) ? x - 16 : x;
          sy   = (m == 1 && y >= 8) ? y - 16 : y;
          prod = sx * sy;
          exp8 = 8'(prod);
          if (lat != 4 || p !== exp8) begin
            check("sweep_lat", 64'(lat), 64'd4);
            check($sformatf("sweep_m%0d_%0dx%0d", m, x, y), 64'(p), 64'(exp8));
            stop = 1'b1;
          end else begin
            total++;
          end
        end
      end
    end

    // WIDTH=8
    run8(8'd255, 8'd255, 1'b0, lat);
    check("w8_u255_lat", 64'(lat), 64'd8);
    check("w8_u255_p",   64'(p8),  64'd65025);
    run8(8'h80, 8'h80, 1'b1, lat);
    check("w8_sm128xm128_p", 64'(p8), 64'h4000);
    run8(8'd127, 8'h80, 1'b1, lat);
    check("w8_s127xm128_p",  64'(p8), 64'hC080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
